// File: rtl/fsm_run_gen.sv
// fsm_run_gen: run-length stimulus transmitter for the 4-in-a-row w/z detector.
// Commands {bit, length} arrive over valid/ready and are serialised onto w,
// one bit per clock, back-to-back with no gap between consecutive runs.
// Optional feature macro: FSM_RUN_GEN_PREDICT_EN builds the z predictor
// (z_exp, run_cnt); without it both outputs are tied to 0.
module fsm_run_gen #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic             z_exp,
    output logic [2:0]       run_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [LEN_W:0] REM_ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] REM_ZERO = {(LEN_W+1){1'b0}};

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W:0]   rem;
    logic [LEN_W:0]   rem_nxt;
    logic [LEN_W:0]   len_ext;
    logic             w_nxt;
    logic             w_valid_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             last_bit;
    logic             accept;

    // A length code of 0 means a full 2**LEN_W run: the extra MSB is set
    // exactly when the low bits are all zero.
    assign len_ext   = {(cmd_len == {LEN_W{1'b0}}), cmd_len};
    assign last_bit  = (state == SEND) && (rem == REM_ONE);
    assign cmd_ready = (state == IDLE) || last_bit;
    assign accept    = cmd_valid && cmd_ready;

    // Next-state and next-output logic; a command accepted on the last bit
    // reloads the run directly so no idle cycle appears on w.
    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        w_nxt       = w;
        w_valid_nxt = w_valid;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = SEND;
                    rem_nxt     = len_ext;
                    w_nxt       = cmd_bit;
                    w_valid_nxt = 1'b1;
                end else begin
                    state_nxt   = IDLE;
                end
            end
            SEND: begin
                if (rem == REM_ONE) begin
                    if (accept) begin
                        state_nxt   = SEND;
                        rem_nxt     = len_ext;
                        w_nxt       = cmd_bit;
                        w_valid_nxt = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        rem_nxt     = REM_ZERO;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
                    rem_nxt = rem - REM_ONE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                rem_nxt     = REM_ZERO;
                w_valid_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt == SEND);
        done_nxt = busy_nxt && (rem_nxt == REM_ONE);
    end

    // State, remaining-bit counter and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= REM_ZERO;
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            w       <= w_nxt;
            w_valid <= w_valid_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

`ifdef FSM_RUN_GEN_PREDICT_EN
    logic [2:0] cnt;
    logic       prev;

    // Track how many consecutive equal w samples the detector has seen,
    // saturating at 4; the detector samples w on every edge, idle or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 3'd0;
            prev <= 1'b0;
        end else begin
            if ((cnt == 3'd0) || (w != prev)) begin
                cnt <= 3'd1;
            end else if (cnt < 3'd4) begin
                cnt <= cnt + 3'd1;
            end else begin
                cnt <= 3'd4;
            end
            prev <= w;
        end
    end

    assign z_exp   = (cnt == 3'd4);
    assign run_cnt = cnt;
`else
    assign z_exp   = 1'b0;
    assign run_cnt = 3'd0;
`endif

endmodule
